// File: rtl/param_serial_alu.sv
// param_serial_alu: serial-load ALU. Opcode and operand A arrive together,
// operand B (binary ops only) on the following cycle. Result and overflow
// are registered and announced by a one-cycle done pulse.
//
// Handshake: opcode_valid is sampled only while the block is idle (busy=0).
// From the cycle after an accepted opcode_valid through the done cycle,
// busy=1 and any opcode_valid is dropped. A new op may be presented in the
// cycle right after done.
module param_serial_alu #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  opcode_valid,
  input  logic [OP_WIDTH-1:0]   opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic [2:0]            dbg_state
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_B   = 3'd1,
    EXEC     = 3'd2,
    MUL_ITER = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q;
  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic [2*W-1:0]        prod_q;
  logic [2*W-1:0]        mcand_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  in_reserved;
  logic                  in_unary;
  logic                  op_reserved;
  logic                  op_is_mul;
  logic                  mul_last;
  logic [2*W-1:0]        prod_next;
  logic [W:0]            sum_ab;
  logic [W:0]            acc_sum;
  logic [W-1:0]          exec_res;
  logic                  exec_ovf;

  // Opcode decode: upper (reserved) opcode bits only exist when OP_WIDTH > 3.
  always_comb begin
    in_reserved = 1'b0;
    op_reserved = 1'b0;
    if (OP_WIDTH > 3) begin
      in_reserved = (opcode >> 3) != '0;
      op_reserved = (op_q >> 3) != '0;
    end
    in_unary  = in_reserved || (opcode[2:0] == OP_NOT) || (opcode[2:0] == OP_ACC);
    op_is_mul = !op_reserved && (op_q[2:0] == OP_MUL);
    mul_last  = (cnt_q == CNT_W'(W - 1));
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    case (state_q)
      IDLE:     if (opcode_valid) state_d = in_unary ? EXEC : LOAD_B;
      LOAD_B:   state_d = op_is_mul ? MUL_ITER : EXEC;
      EXEC:     state_d = DONE;
      MUL_ITER: if (mul_last) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Single-cycle result for every op except MUL; reserved ops yield 0.
  always_comb begin
    exec_res = '0;
    exec_ovf = 1'b0;
    sum_ab   = {1'b0, a_q} + {1'b0, b_q};
    acc_sum  = {1'b0, result} + {1'b0, a_q};
    if (!op_reserved) begin
      case (op_q[2:0])
        OP_ADD: begin exec_res = sum_ab[W-1:0];  exec_ovf = sum_ab[W]; end
        OP_SUB: begin exec_res = a_q - b_q;      exec_ovf = (a_q < b_q); end
        OP_AND: exec_res = a_q & b_q;
        OP_OR:  exec_res = a_q | b_q;
        OP_XOR: exec_res = a_q ^ b_q;
        OP_NOT: exec_res = ~a_q;
        OP_ACC: begin exec_res = acc_sum[W-1:0]; exec_ovf = acc_sum[W]; end
        default: ;
      endcase
    end
  end

  // Shift-add step: consume the multiplier LSB, add the shifted multiplicand.
  always_comb begin
    prod_next = prod_q + (b_q[0] ? mcand_q : '0);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Operand capture, multiplier datapath and result/overflow registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (opcode_valid) begin
            op_q <= opcode;
            a_q  <= data;
          end
        end
        LOAD_B: begin
          b_q     <= data;
          prod_q  <= '0;
          mcand_q <= {{W{1'b0}}, a_q};
          cnt_q   <= '0;
        end
        EXEC: begin
          result   <= exec_res;
          overflow <= exec_ovf;
        end
        MUL_ITER: begin
          prod_q  <= prod_next;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (mul_last) begin
            result   <= prod_next[W-1:0];
            overflow <= |prod_next[2*W-1:W];
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_param_serial_alu.sv
// Bench for param_serial_alu: an 8-bit and a 16-bit instance share clock
// and reset. Directed vectors from a table plus hand-written sequences for
// reset, busy rejection and abort.
module tb_param_serial_alu;

  logic        clk;
  logic        reset_n;

  logic        v8, v16;
  logic [2:0]  op8, op16;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic        busy8, done8, ovf8, busy16, done16, ovf16;
  logic [7:0]  res8;
  logic [15:0] res16;
  logic [2:0]  dbg8, dbg16;

  int n_checks = 0;
  int n_errors = 0;

  param_serial_alu #(.DATA_WIDTH(8), .OP_WIDTH(3)) dut8 (
    .clk(clk), .reset_n(reset_n), .opcode_valid(v8), .opcode(op8), .data(d8),
    .busy(busy8), .done(done8), .result(res8), .overflow(ovf8), .dbg_state(dbg8)
  );

  param_serial_alu #(.DATA_WIDTH(16), .OP_WIDTH(3)) dut16 (
    .clk(clk), .reset_n(reset_n), .opcode_valid(v16), .opcode(op16), .data(d16),
    .busy(busy16), .done(done16), .result(res16), .overflow(ovf16), .dbg_state(dbg16)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w16;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] res;
    logic        ovf;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic s_busy(input logic w16);
    return w16 ? busy16 : busy8;
  endfunction
  function automatic logic s_done(input logic w16);
    return w16 ? done16 : done8;
  endfunction
  function automatic logic [15:0] s_res(input logic w16);
    return w16 ? res16 : {8'h00, res8};
  endfunction
  function automatic logic s_ovf(input logic w16);
    return w16 ? ovf16 : ovf8;
  endfunction

  task automatic drive(input logic w16, input logic v, input logic [2:0] op, input logic [15:0] d);
    if (w16) begin v16 = v; op16 = op; d16 = d; end
    else     begin v8 = v;  op8 = op;  d8 = d[7:0]; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 16'd0);
    drive(1'b1, 1'b0, 3'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Driver + checker for one operation; done latency is counted from the
  // opcode_valid cycle T.
  task automatic run_op(input vec_t v);
    int  lat;
    bit  busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    @(posedge clk); #1;
    drive(v.w16, 1'b1, v.op, v.a);
    @(negedge clk);
    check({v.name, "_idle_busy"}, 32'(s_busy(v.w16)), 32'd0);
    @(posedge clk); #1;
    drive(v.w16, 1'b0, 3'd0, v.b);
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      if (!s_busy(v.w16)) busy_ok = 1'b0;
      if (s_done(v.w16)) lat = i;
      else begin
        @(posedge clk); #1;
        drive(v.w16, 1'b0, 3'd0, 16'hA5C3);
      end
    end
    check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    check({v.name, "_result"}, 32'(s_res(v.w16)), 32'(v.res));
    check({v.name, "_overflow"}, 32'(s_ovf(v.w16)), 32'(v.ovf));
    check({v.name, "_busy_held"}, 32'(busy_ok), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check({v.name, "_done_pulse"}, 32'({s_done(v.w16), s_busy(v.w16)}), 32'd0);
  endtask

  initial begin
    int   n_done;
    int   done_at;
    vec_t hv;

    vecs[0]  = '{1'b0, 3'b000, 16'd200,  16'd100,  3, 16'd44,   1'b1, "add_carry"};
    vecs[1]  = '{1'b0, 3'b001, 16'd5,    16'd7,    3, 16'hFE,   1'b1, "sub_borrow"};
    vecs[2]  = '{1'b0, 3'b010, 16'hF0,   16'h3C,   3, 16'h30,   1'b0, "and"};
    vecs[3]  = '{1'b0, 3'b011, 16'hF0,   16'h0F,   3, 16'hFF,   1'b0, "or"};
    vecs[4]  = '{1'b0, 3'b100, 16'hFF,   16'h0F,   3, 16'hF0,   1'b0, "xor"};
    vecs[5]  = '{1'b0, 3'b101, 16'h5A,   16'h00,   2, 16'hA5,   1'b0, "not"};
    vecs[6]  = '{1'b0, 3'b110, 16'd16,   16'd17,  10, 16'h10,   1'b1, "mul_ovf"};
    vecs[7]  = '{1'b0, 3'b110, 16'd12,   16'd10,  10, 16'd120,  1'b0, "mul"};
    vecs[8]  = '{1'b0, 3'b000, 16'd20,   16'd24,   3, 16'd44,   1'b0, "add"};
    vecs[9]  = '{1'b0, 3'b111, 16'd6,    16'd0,    2, 16'd50,   1'b0, "acc"};
    vecs[10] = '{1'b0, 3'b111, 16'hF0,   16'd0,    2, 16'h22,   1'b1, "acc_carry"};
    vecs[11] = '{1'b0, 3'b110, 16'hFF,   16'hFF,  10, 16'h01,   1'b1, "mul_max"};
    vecs[12] = '{1'b0, 3'b110, 16'd0,    16'd99,  10, 16'd0,    1'b0, "mul_zero"};
    vecs[13] = '{1'b0, 3'b001, 16'd7,    16'd7,    3, 16'd0,    1'b0, "sub_equal"};
    vecs[14] = '{1'b1, 3'b110, 16'd300,  16'd300, 18, 16'h5F90, 1'b1, "mul16"};
    vecs[15] = '{1'b1, 3'b000, 16'hFFFF, 16'd1,    3, 16'd0,    1'b1, "add16_wrap"};

    do_reset();
    @(negedge clk);
    check("rst_busy",     32'(busy8),     32'd0);
    check("rst_done",     32'(done8),     32'd0);
    check("rst_result",   32'(res8),      32'd0);
    check("rst_overflow", 32'(ovf8),      32'd0);
    check("rst_state",    32'(dbg8),      32'd0);
    check("rst_result16", 32'(res16),     32'd0);

    for (int k = 0; k < 16; k++) run_op(vecs[k]);

    // ACC as the first op after reset returns A.
    do_reset();
    hv = '{1'b0, 3'b111, 16'd9, 16'd0, 2, 16'd9, 1'b0, "acc_first"};
    run_op(hv);

    // Busy rejection: opcode_valid pulses through a MUL, including DONE.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'b110, 16'd12);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 16'd10);
    n_done  = 0;
    done_at = -1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (done8) begin n_done++; done_at = i; end
      @(posedge clk); #1;
      if (i + 1 <= 10)
        drive(1'b0, ((i % 2) == 1) || (i + 1 == 10), 3'b000, 16'($urandom_range(0, 255)));
      else
        drive(1'b0, 1'b0, 3'd0, 16'd0);
    end
    check("rej_done_count", 32'(n_done),  32'd1);
    check("rej_done_cycle", 32'(done_at), 32'd10);
    check("rej_result",     32'(res8),    32'd120);
    check("rej_overflow",   32'(ovf8),    32'd0);

    // Reset in the middle of a MUL aborts with no done.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'b110, 16'd16);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 16'd17);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_busy",     32'(busy8), 32'd0);
    check("abort_done",     32'(done8), 32'd0);
    check("abort_result",   32'(res8),  32'd0);
    check("abort_overflow", 32'(ovf8),  32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    hv = '{1'b0, 3'b000, 16'd20, 16'd24, 3, 16'd44, 1'b0, "add_after_abort"};
    run_op(hv);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_serial_alu.md
Name: param_serial_alu

Overview:
- Parametrised, sequential successor to the 8-bit serial-opcode ALU.
- Accepts an opcode and operands serially over a shared data bus, then computes through a small FSM with an iterative multiplier.
- Returns a registered result with a one-cycle done pulse and an overflow flag.
- Sits between the test driver and checker in the ALU bench, on the same clk/reset_n as the rest of the design.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits (legal values >= 4).
- OP_WIDTH, 3, opcode width in bits (fixed encoding below; upper opcodes reserved if widened).

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- opcode_valid  input  1  opcode and operand A are present this cycle.
- opcode  input  OP_WIDTH  operation select; sampled only with opcode_valid.
- data  input  DATA_WIDTH  operand A (with opcode_valid), operand B (the following cycle).
- busy  output  1  high from the cycle after an accepted opcode_valid through the done cycle.
- done  output  1  one-cycle pulse; result/overflow are valid in this cycle.
- result  output  DATA_WIDTH  registered result; holds until the next done.
- overflow  output  1  registered overflow flag; updates with result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, result=0, overflow=0; accumulator, operands and counter cleared.
- Reset mid-operation aborts the operation; no done is produced.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT: unary, ~A.
  - 110 MUL: A*B, iterative.
  - 111 ACC: unary, result_prev + A.
- Overflow:
  - ADD, ACC: carry-out of DATA_WIDTH-bit unsigned add.
  - SUB: borrow (A<B unsigned).
  - MUL: any nonzero bit in the upper DATA_WIDTH of the 2*DATA_WIDTH product.
  - Logical ops (AND, OR, XOR, NOT): 0.
- result is always the low DATA_WIDTH bits.
- FSM states: IDLE, LOAD_B, EXEC, MUL_ITER, DONE.
  - IDLE: opcode_valid=1 at cycle T latches opcode and A. Binary op -> LOAD_B; unary op -> EXEC.
  - LOAD_B (T+1): latch data as B. MUL -> MUL_ITER; others -> EXEC.
  - EXEC: compute and register result/overflow -> DONE.
  - MUL_ITER: shift-add one multiplier bit per cycle, LSB first, over exactly DATA_WIDTH cycles; a counter counts 0..DATA_WIDTH-1. Last iteration registers result/overflow -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency (cycle in which done=1):
  - Unary: T+2.
  - Binary non-MUL: T+3.
  - MUL: T+2+DATA_WIDTH.
- Handshake:
  - opcode_valid is honoured only in IDLE.
  - opcode_valid while busy=1 (including the DONE cycle) is ignored entirely; no queueing.
  - A new op may start in the cycle after done.
- Accumulator:
  - result_prev is the last done result, 0 after reset.
  - ACC as the first op after reset yields A.
- Unused/reserved opcodes (only when OP_WIDTH>3): treated as NOT-style unary returning 0 with overflow=0 and normal unary latency.
- busy and done are never both low while state != IDLE; done never asserts in IDLE.

Test Plan (DATA_WIDTH=8 unless noted):
- Reset then ADD: opcode_valid@T with op=000, A=200; B=100 @T+1 -> done@T+3, result=44 (0x2C), overflow=1, busy high T+1..T+3.
- SUB: A=5, B=7 -> result=0xFE, overflow=1. AND A=0xF0, B=0x3C -> 0x30, overflow=0, done@T+3.
- MUL: A=16, B=17 -> done@T+10, result=0x10, overflow=1. MUL A=12, B=10 -> 120, overflow=0.
- ACC chaining: ADD 20+24 -> 44; then ACC A=6 -> done@T+2, result=50, overflow=0; ACC first after reset with A=9 -> 9.
- Busy rejection and reset: opcode_valid pulses during a MUL (including the DONE cycle) -> no extra done, result unaffected. reset_n low mid-MUL -> outputs 0 immediately, no done; the next ADD after release works normally.
- DATA_WIDTH=16 build: MUL A=300, B=300 -> done@T+18, result=0x5F90, overflow=1. ADD 0xFFFF+1 -> 0, overflow=1.
